// File: rtl/cache_ctrl_assoc_if.sv
// ---------------------------------------------------------------------------
// cache_ctrl_assoc_if
// Bundles the request, array-status, memory-status and control-output signals
// of the associative cache controller.
//   slave  : the controller (takes requests/status, drives array/memory strobes)
//   master : the CPU / array / memory side that drives requests and status
// Signals:
//   rd, wr, index          CPU request and set index
//   hit, valid, dirty      per-way status of the addressed set
//   mem_stall, cache_err,  memory back-pressure and error inputs
//   mem_err
//   comp, way_sel,         array control (compare mode, one-hot way, word)
//   word_sel, cache_wr
//   mem_rd, mem_wr         memory requests
//   stall, done, hit_out,  CPU-side status
//   err
// ---------------------------------------------------------------------------
interface cache_ctrl_assoc_if #(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int INDEX_W = 8
);
    localparam int WORD_W = $clog2(WORDS);

    logic               rd;
    logic               wr;
    logic [INDEX_W-1:0] index;
    logic [WAYS-1:0]    hit;
    logic [WAYS-1:0]    valid;
    logic [WAYS-1:0]    dirty;
    logic               mem_stall;
    logic               cache_err;
    logic               mem_err;

    logic               comp;
    logic [WAYS-1:0]    way_sel;
    logic [WORD_W-1:0]  word_sel;
    logic               cache_wr;
    logic               mem_rd;
    logic               mem_wr;
    logic               stall;
    logic               done;
    logic               hit_out;
    logic               err;

    modport slave (
        input  rd, wr, index, hit, valid, dirty, mem_stall, cache_err, mem_err,
        output comp, way_sel, word_sel, cache_wr, mem_rd, mem_wr,
               stall, done, hit_out, err
    );

    modport master (
        output rd, wr, index, hit, valid, dirty, mem_stall, cache_err, mem_err,
        input  comp, way_sel, word_sel, cache_wr, mem_rd, mem_wr,
               stall, done, hit_out, err
    );
endinterface

// File: rtl/cache_ctrl_assoc.sv
// ---------------------------------------------------------------------------
// cache_ctrl_assoc
// Control FSM for a 1- or 2-way write-back, write-allocate cache with
// multi-word lines. Compares tags, picks a victim (first invalid way, else
// per-set LRU), writes back a dirty victim, fills the line through a
// pipelined memory with fixed read latency, then retries the access.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  cache_ctrl_assoc_if.slave  request/status in, array/memory strobes out
// ---------------------------------------------------------------------------
module cache_ctrl_assoc #(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 4,
    parameter int INDEX_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    cache_ctrl_assoc_if.slave bus
);
    localparam int WORD_W = $clog2(WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam logic [CNT_W-1:0] C_WORDS = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_WB, S_FILL, S_RETRY, S_ERR
    } state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_wcnt, r_icnt, r_rcnt;
    logic [CNT_W-1:0]   w_wcnt_next, w_icnt_next, w_rcnt_next;
    logic               w_cnt_clr;
    logic [WAYS-1:0]    r_victim, w_victim_next, w_victim, w_hv;
    logic               w_victim_dirty;
    logic [MEM_LAT-1:0] r_pipe;
    logic [MEM_LAT:0]   w_pipe_ext;
    logic               w_rd_accept;
    logic               w_fault;
    logic               w_lru_we, w_lru_from_victim;

    logic               w_comp, w_cache_wr, w_mem_rd, w_mem_wr;
    logic               w_done, w_hit_out, w_err;
    logic [WAYS-1:0]    w_way_sel;
    logic [WORD_W-1:0]  w_word_sel;

    assign w_hv           = bus.hit & bus.valid;
    assign w_fault        = bus.cache_err | bus.mem_err;
    assign w_victim_dirty = |(w_victim & bus.valid & bus.dirty);
    // Bit k of the pipe marks a read accepted k+1 cycles ago; the top bit is
    // the read whose data is on the memory bus this cycle.
    assign w_pipe_ext     = {r_pipe, w_rd_accept};

    // Victim choice and per-set LRU. The LRU bit names the way to evict next.
    generate
        if (WAYS == 2) begin : g_lru
            logic [(2**INDEX_W)-1:0] r_lru;

            assign w_victim = !bus.valid[0] ? 2'b01 :
                              !bus.valid[1] ? 2'b10 :
                              (r_lru[bus.index] ? 2'b10 : 2'b01);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lru <= '0;
                end else if (w_lru_we) begin
                    // Point LRU at the way that was not just used.
                    r_lru[bus.index] <= w_lru_from_victim ? ~r_victim[1] : ~w_hv[1];
                end
            end
        end else begin : g_dm
            assign w_victim = '1;
        end
    endgenerate

    always_comb begin
        w_state_next      = r_state;
        w_wcnt_next       = r_wcnt;
        w_icnt_next       = r_icnt;
        w_rcnt_next       = r_rcnt;
        w_cnt_clr         = 1'b0;
        w_victim_next     = r_victim;
        w_rd_accept       = 1'b0;
        w_lru_we          = 1'b0;
        w_lru_from_victim = 1'b0;
        w_comp            = 1'b0;
        w_way_sel         = '0;
        w_word_sel        = '0;
        w_cache_wr        = 1'b0;
        w_mem_rd          = 1'b0;
        w_mem_wr          = 1'b0;
        w_done            = 1'b0;
        w_hit_out         = 1'b0;
        w_err             = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.rd | bus.wr) w_state_next = S_CMP;
            end

            // An error cycle drives no strobes; the error completion follows in S_ERR.
            S_CMP: begin
                if (w_fault) begin
                    w_state_next = S_ERR;
                end else begin
                    w_comp = 1'b1;
                    if (|w_hv) begin
                        w_way_sel    = w_hv;
                        w_cache_wr   = bus.wr;
                        w_done       = 1'b1;
                        w_hit_out    = 1'b1;
                        w_lru_we     = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_victim_next = w_victim;
                        w_cnt_clr     = 1'b1;
                        w_state_next  = w_victim_dirty ? S_WB : S_FILL;
                    end
                end
            end

            S_WB: begin
                if (w_fault) begin
                    w_state_next = S_ERR;
                end else begin
                    w_way_sel  = r_victim;
                    w_word_sel = r_wcnt[WORD_W-1:0];
                    w_mem_wr   = 1'b1;
                    if (!bus.mem_stall) begin
                        if (r_wcnt == C_LAST) begin
                            w_cnt_clr    = 1'b1;
                            w_state_next = S_FILL;
                        end else begin
                            w_wcnt_next = r_wcnt + C_ONE;
                        end
                    end
                end
            end

            // Issue and return run concurrently; word_sel tracks the return side.
            S_FILL: begin
                if (w_fault) begin
                    w_state_next = S_ERR;
                end else begin
                    w_way_sel   = r_victim;
                    w_word_sel  = r_rcnt[WORD_W-1:0];
                    w_mem_rd    = (r_icnt < C_WORDS);
                    w_rd_accept = w_mem_rd & ~bus.mem_stall;
                    if (w_rd_accept) w_icnt_next = r_icnt + C_ONE;
                    if (r_pipe[MEM_LAT-1]) begin
                        w_cache_wr  = 1'b1;
                        w_rcnt_next = r_rcnt + C_ONE;
                    end
                    if (r_rcnt == C_WORDS) w_state_next = S_RETRY;
                end
            end

            S_RETRY: begin
                if (w_fault) begin
                    w_state_next = S_ERR;
                end else begin
                    w_comp            = 1'b1;
                    w_way_sel         = w_hv;
                    w_cache_wr        = bus.wr;
                    w_done            = 1'b1;
                    w_lru_we          = 1'b1;
                    w_lru_from_victim = 1'b1;
                    w_state_next      = S_IDLE;
                end
            end

            S_ERR: begin
                w_done       = 1'b1;
                w_err        = 1'b1;
                w_state_next = S_IDLE;
            end

            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wcnt   <= '0;
            r_icnt   <= '0;
            r_rcnt   <= '0;
            r_victim <= '0;
            r_pipe   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_victim <= w_victim_next;
            if (w_cnt_clr) begin
                // Entering WB or FILL: restart counters and drop any stale returns.
                r_wcnt <= '0;
                r_icnt <= '0;
                r_rcnt <= '0;
                r_pipe <= '0;
            end else begin
                r_wcnt <= w_wcnt_next;
                r_icnt <= w_icnt_next;
                r_rcnt <= w_rcnt_next;
                r_pipe <= w_pipe_ext[MEM_LAT-1:0];
            end
        end
    end

    assign bus.comp     = w_comp;
    assign bus.way_sel  = w_way_sel;
    assign bus.word_sel = w_word_sel;
    assign bus.cache_wr = w_cache_wr;
    assign bus.mem_rd   = w_mem_rd;
    assign bus.mem_wr   = w_mem_wr;
    assign bus.done     = w_done;
    assign bus.hit_out  = w_hit_out;
    assign bus.err      = w_err;
    assign bus.stall    = (r_state != S_IDLE) & ~w_done;
endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_assoc
// Directed bench for cache_ctrl_assoc: a 2-way instance and a direct-mapped
// (WAYS=1) instance, both WORDS=4, MEM_LAT=4. Each request is run cycle by
// cycle; cycle 0 is the IDLE cycle in which the request is first presented,
// cycle 1 is CMP. Observed timing/ordering is compared to hand-derived values.
// ---------------------------------------------------------------------------
module tb_cache_ctrl_assoc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_assoc_if #(.WAYS(2), .WORDS(4), .INDEX_W(8)) b ();
    cache_ctrl_assoc_if #(.WAYS(1), .WORDS(4), .INDEX_W(8)) d ();

    cache_ctrl_assoc #(.WAYS(2), .WORDS(4), .MEM_LAT(4), .INDEX_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    cache_ctrl_assoc #(.WAYS(1), .WORDS(4), .MEM_LAT(4), .INDEX_W(8)) u_dm (
        .clk (clk),
        .rst (rst),
        .bus (d)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-transaction observations
    int         res_done, res_first_rd, res_rd_cyc, res_first_fill, res_nfill;
    int         res_wb_cyc, res_nwb, res_bad_stall;
    logic [7:0] res_wb_seq, res_fill_seq;
    logic [1:0] res_way, res_done_way;
    logic       res_hit_out, res_err, res_done_cwr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {comp, way_sel[1:0], word_sel[1:0], cache_wr, mem_rd, mem_wr, stall, done, hit_out, err}
    function automatic logic [11:0] outs(input bit dm);
        if (dm)
            return {d.comp, 1'b0, d.way_sel, d.word_sel, d.cache_wr, d.mem_rd, d.mem_wr,
                    d.stall, d.done, d.hit_out, d.err};
        return {b.comp, b.way_sel, b.word_sel, b.cache_wr, b.mem_rd, b.mem_wr,
                b.stall, b.done, b.hit_out, b.err};
    endfunction

    task automatic drv(input bit dm, input logic rd_v, input logic wr_v, input logic [7:0] idx,
                       input logic [1:0] hit_v, input logic [1:0] vld_v, input logic [1:0] drt_v,
                       input logic stl, input logic er);
        if (dm) begin
            d.rd = rd_v; d.wr = wr_v; d.index = idx;
            d.hit = hit_v[0]; d.valid = vld_v[0]; d.dirty = drt_v[0];
            d.mem_stall = stl; d.mem_err = er; d.cache_err = 1'b0;
        end else begin
            b.rd = rd_v; b.wr = wr_v; b.index = idx;
            b.hit = hit_v; b.valid = vld_v; b.dirty = drt_v;
            b.mem_stall = stl; b.mem_err = er; b.cache_err = 1'b0;
        end
    endtask

    // Runs one request; called and returns at posedge+1. The array model makes
    // the filled way hit once fill writes have been seen.
    task automatic run_req(input string name, input bit dm, input logic is_wr, input logic [7:0] idx,
                           input logic [1:0] hit0, input logic [1:0] vld, input logic [1:0] drt,
                           input logic [63:0] stall_m, input logic [63:0] err_m, input int abort_at);
        logic [1:0] hitv;
        logic       o_comp, o_cwr, o_mrd, o_mwr, o_stall, o_done, o_hit, o_err;
        logic [1:0] o_way, o_word;
        res_done = -1; res_first_rd = -1; res_rd_cyc = 0; res_first_fill = -1; res_nfill = 0;
        res_wb_cyc = 0; res_nwb = 0; res_bad_stall = 0; res_wb_seq = '0; res_fill_seq = '0;
        res_way = '0; res_done_way = '0; res_hit_out = 1'b0; res_err = 1'b0; res_done_cwr = 1'b0;
        hitv = hit0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            drv(dm, ~is_wr, is_wr, idx, hitv, vld, drt, stall_m[cyc], err_m[cyc]);
            @(negedge clk);
            {o_comp, o_way, o_word, o_cwr, o_mrd, o_mwr, o_stall, o_done, o_hit, o_err} = outs(dm);
            if (cyc > 0 && o_stall == o_done) res_bad_stall++;
            if (o_mrd) begin
                res_rd_cyc++;
                if (res_first_rd < 0) res_first_rd = cyc;
            end
            if (o_mwr) begin
                res_wb_cyc++;
                if (!stall_m[cyc]) begin
                    res_nwb++;
                    res_wb_seq = {res_wb_seq[5:0], o_word};
                end
            end
            if (!o_comp && o_way != 2'b00 && res_way == 2'b00) res_way = o_way;
            if (o_cwr && !o_comp) begin
                res_nfill++;
                res_fill_seq = {res_fill_seq[5:0], o_word};
                if (res_first_fill < 0) res_first_fill = cyc;
                hitv = o_way;
            end
            if (cyc == abort_at) begin
                $display("txn %s aborted at cycle %0d way=%b", name, cyc, res_way);
                return;
            end
            if (o_done) begin
                res_done = cyc; res_hit_out = o_hit; res_err = o_err;
                res_done_cwr = o_cwr; res_done_way = o_way;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        drv(dm, 1'b0, 1'b0, idx, 2'b00, vld, drt, 1'b0, 1'b0);
        $display("txn %s done@%0d hit=%0b err=%0b way=%b wb=%0d fill=%0d", name, res_done,
                 res_hit_out, res_err, res_way, res_nwb, res_nfill);
    endtask

    // Clean-miss expectations shared by several transactions (MEM_LAT=4, WORDS=4)
    task automatic check_clean_fill(input string tag, input logic [1:0] way);
        check({tag, "_way"}, 32'(res_way), 32'(way));
        check({tag, "_first_rd"}, res_first_rd, 2);
        check({tag, "_rd_cyc"}, res_rd_cyc, 4);
        check({tag, "_first_fill"}, res_first_fill, 6);
        check({tag, "_fill_seq"}, 32'(res_fill_seq), 32'h1B);
        check({tag, "_done"}, res_done, 11);
        check({tag, "_hit_out"}, 32'(res_hit_out), 0);
        check({tag, "_nwb"}, res_nwb, 0);
        check({tag, "_stall"}, res_bad_stall, 0);
    endtask

    localparam logic [63:0] NONE = 64'd0;

    initial begin
        int cwr_cnt, stl_cnt;
        rst = 1'b1;
        drv(1'b0, 1'b1, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("reset_outs_w2", 32'(outs(1'b0)), 0);
        check("reset_outs_w1", 32'(outs(1'b1)), 0);
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Read hit in way 1 -> LRU[5]=0
        run_req("t1_rd_hit", 1'b0, 1'b0, 8'd5, 2'b10, 2'b11, 2'b00, NONE, NONE, -1);
        check("t1_done", res_done, 1);
        check("t1_hit_out", 32'(res_hit_out), 1);
        check("t1_way", 32'(res_done_way), 32'h2);
        check("t1_cache_wr", 32'(res_done_cwr), 0);

        // Write hit in way 0 at set 6 -> LRU[6]=1
        run_req("t1b_wr_hit", 1'b0, 1'b1, 8'd6, 2'b01, 2'b11, 2'b00, NONE, NONE, -1);
        check("t1b_done", res_done, 1);
        check("t1b_hit_out", 32'(res_hit_out), 1);
        check("t1b_cache_wr", 32'(res_done_cwr), 1);
        check("t1b_way", 32'(res_done_way), 32'h1);

        // Clean miss, both valid, LRU[5]=0 -> fill way 0; then LRU[5]=1
        run_req("t2_clean_miss", 1'b0, 1'b0, 8'd5, 2'b00, 2'b11, 2'b00, NONE, NONE, -1);
        check_clean_fill("t2", 2'b01);
        check("t2_retry_way", 32'(res_done_way), 32'h1);

        // Dirty write miss, LRU[5]=1 -> writeback + fill way 1; then LRU[5]=0
        run_req("t3_dirty_miss", 1'b0, 1'b1, 8'd5, 2'b00, 2'b11, 2'b11, NONE, NONE, -1);
        check("t3_way", 32'(res_way), 32'h2);
        check("t3_nwb", res_nwb, 4);
        check("t3_wb_seq", 32'(res_wb_seq), 32'h1B);
        check("t3_first_rd", res_first_rd, 6);
        check("t3_first_fill", res_first_fill, 10);
        check("t3_fill_seq", 32'(res_fill_seq), 32'h1B);
        check("t3_done", res_done, 15);
        check("t3_retry_cache_wr", 32'(res_done_cwr), 1);
        check("t3_hit_out", 32'(res_hit_out), 0);

        // Dirty miss with stalls on WB word 1 (cycles 3,4) and FILL issue 2 (10,11)
        run_req("t4_stalls", 1'b0, 1'b0, 8'd5, 2'b00, 2'b11, 2'b11,
                (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 10) | (64'd1 << 11), NONE, -1);
        check("t4_way", 32'(res_way), 32'h1);
        check("t4_wb_cyc", res_wb_cyc, 6);
        check("t4_nwb", res_nwb, 4);
        check("t4_wb_seq", 32'(res_wb_seq), 32'h1B);
        check("t4_rd_cyc", res_rd_cyc, 6);
        check("t4_first_fill", res_first_fill, 12);
        check("t4_fill_seq", 32'(res_fill_seq), 32'h1B);
        check("t4_nfill", res_nfill, 4);
        check("t4_done", res_done, 19);
        check("t4_stall", res_bad_stall, 0);

        // Miss with way 0 valid -> victim way 1; memory error in FILL cycle 3
        run_req("t5_mem_err", 1'b0, 1'b0, 8'd9, 2'b00, 2'b01, 2'b00, NONE, 64'd1 << 3, -1);
        check("t5_way", 32'(res_way), 32'h2);
        check("t5_done", res_done, 4);
        check("t5_err", 32'(res_err), 1);
        check("t5_hit_out", 32'(res_hit_out), 0);
        check("t5_nfill", res_nfill, 0);
        cwr_cnt = 0; stl_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b.cache_wr) cwr_cnt++;
            if (b.stall) stl_cnt++;
            @(posedge clk); #1;
        end
        check("t5_late_cache_wr", cwr_cnt, 0);
        check("t5_idle_stall", stl_cnt, 0);

        // Set 6 has LRU=1 from the way-0 write hit -> clean miss fills way 1
        run_req("t7_lru_set6", 1'b0, 1'b0, 8'd6, 2'b00, 2'b11, 2'b00, NONE, NONE, -1);
        check_clean_fill("t7", 2'b10);

        // Reset in the middle of a fill
        run_req("t6_rst_fill", 1'b0, 1'b0, 8'd10, 2'b00, 2'b00, 2'b00, NONE, NONE, 4);
        check("t6_way", 32'(res_way), 32'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_outs", 32'(outs(1'b0)), 0);
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // LRU[5] was 1 before reset; reset clears it so way 0 is the victim
        run_req("t6b_after_rst", 1'b0, 1'b0, 8'd5, 2'b00, 2'b11, 2'b00, NONE, NONE, -1);
        check_clean_fill("t6b", 2'b01);

        // Direct-mapped build
        run_req("d1_hit", 1'b1, 1'b0, 8'd5, 2'b01, 2'b01, 2'b00, NONE, NONE, -1);
        check("d1_done", res_done, 1);
        check("d1_hit_out", 32'(res_hit_out), 1);
        check("d1_way", 32'(res_done_way), 32'h1);
        run_req("d2_clean_miss", 1'b1, 1'b0, 8'd5, 2'b00, 2'b01, 2'b00, NONE, NONE, -1);
        check_clean_fill("d2", 2'b01);
        run_req("d3_dirty_miss", 1'b1, 1'b1, 8'd7, 2'b00, 2'b01, 2'b01, NONE, NONE, -1);
        check("d3_nwb", res_nwb, 4);
        check("d3_wb_seq", 32'(res_wb_seq), 32'h1B);
        check("d3_done", res_done, 15);
        check("d3_retry_cache_wr", 32'(res_done_cwr), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
